// File: rtl/mimo_frame_collector.sv
// Ping-pong deserialiser: collects a serial stream of complex words into an
// N_ROW x N_COL matrix H plus an N_ROW vector Y, and hands frames out via valid/ready.

module mfc_slot #(
  parameter int W = 48
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_we,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     o_q <= '0;
    else if (i_we) o_q <= i_d;
  end
endmodule

module mimo_frame_collector #(
  parameter int N_ROW  = 4,
  parameter int N_COL  = 4,
  parameter int DATA_W = 48
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_input_valid,
  input  logic [DATA_W-1:0]               i_data,
  input  logic                            i_flush,
  output logic                            o_in_ready,
  output logic                            o_data_valid,
  input  logic                            i_data_ready,
  output logic [N_ROW*N_COL*DATA_W-1:0]   o_h,
  output logic [N_ROW*DATA_W-1:0]         o_y,
  output logic                            o_overflow
);
  localparam int CW = $clog2(N_COL + 1);
  localparam int RW = (N_ROW > 1) ? $clog2(N_ROW) : 1;

  logic [CW-1:0] col, col_d;
  logic [RW-1:0] row, row_d;
  logic          wr_sel, wr_d;
  logic          rd_sel, rd_d;
  logic [1:0]    full, full_d;
  logic          ovf_d;
  logic          accept, consume, last, y_slot;

  logic [1:0][N_ROW*N_COL-1:0][DATA_W-1:0] h_q;
  logic [1:0][N_ROW-1:0][DATA_W-1:0]       y_q;

  // With two banks, the write bank is only full when both are occupied.
  assign o_in_ready   = !full[wr_sel];
  assign o_data_valid = full[rd_sel];
  assign accept       = i_input_valid & o_in_ready & !i_flush;
  assign consume      = o_data_valid & i_data_ready;
  assign y_slot       = (col == CW'(N_COL));
  assign last         = y_slot && (row == RW'(N_ROW - 1));

  always_comb begin
    col_d  = col;
    row_d  = row;
    wr_d   = wr_sel;
    rd_d   = rd_sel;
    full_d = full;
    ovf_d  = o_overflow;
    if (i_flush) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (y_slot) begin
        col_d = '0;
        if (last) begin
          row_d          = '0;
          full_d[wr_sel] = 1'b1;
          wr_d           = ~wr_sel;
        end else begin
          row_d = row + 1'b1;
        end
      end else begin
        col_d = col + 1'b1;
      end
    end else if (i_input_valid && !o_in_ready) begin
      ovf_d = 1'b1;
    end
    // Completion only targets a free bank, consume only a full one: never the same bank.
    if (consume) begin
      full_d[rd_sel] = 1'b0;
      rd_d           = ~rd_sel;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col        <= '0;
      row        <= '0;
      wr_sel     <= 1'b0;
      rd_sel     <= 1'b0;
      full       <= 2'b00;
      o_overflow <= 1'b0;
    end else begin
      col        <= col_d;
      row        <= row_d;
      wr_sel     <= wr_d;
      rd_sel     <= rd_d;
      full       <= full_d;
      o_overflow <= ovf_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar r = 0; r < N_ROW; r++) begin : g_row
      logic row_hit;
      assign row_hit = accept && (wr_sel == 1'(b)) && (row == RW'(r));
      for (genvar c = 0; c < N_COL; c++) begin : g_col
        mfc_slot #(.W(DATA_W)) u_h (
          .i_clk (i_clk),
          .i_rst (i_rst),
          .i_we  (row_hit && (col == CW'(c))),
          .i_d   (i_data),
          .o_q   (h_q[b][r*N_COL+c])
        );
      end
      mfc_slot #(.W(DATA_W)) u_y (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_we  (row_hit && y_slot),
        .i_d   (i_data),
        .o_q   (y_q[b][r])
      );
    end
  end

  assign o_h = h_q[rd_sel];
  assign o_y = y_q[rd_sel];

endmodule

// File: tb/tb_mimo_frame_collector.sv
// Randomised bench for mimo_frame_collector at the default and a small parameter set,
// checked against a frame-queue reference model.

module tb_mimo_frame_collector;
  localparam int MAXF = 20;
  typedef logic [MAXF*48-1:0] frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0, flush = 1'b0, rdy = 1'b0;
  logic [47:0] data = '0;
  int          sel = 0;

  always #5 clk = ~clk;

  logic         rdy0, dv0, ovf0, rdy1, dv1, ovf1;
  logic [767:0] h0;
  logic [191:0] y0;
  logic [95:0]  h1;
  logic [31:0]  y1;

  mimo_frame_collector u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_input_valid(vld && sel == 0), .i_data(data),
    .i_flush(flush && sel == 0), .o_in_ready(rdy0), .o_data_valid(dv0),
    .i_data_ready(rdy && sel == 0), .o_h(h0), .o_y(y0), .o_overflow(ovf0)
  );

  mimo_frame_collector #(.N_ROW(2), .N_COL(3), .DATA_W(16)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_input_valid(vld && sel == 1), .i_data(data[15:0]),
    .i_flush(flush && sel == 1), .o_in_ready(rdy1), .o_data_valid(dv1),
    .i_data_ready(rdy && sel == 1), .o_h(h1), .o_y(y1), .o_overflow(ovf1)
  );

  logic         obs_ready, obs_valid, obs_ovf;
  logic [767:0] obs_h;
  logic [191:0] obs_y;
  always_comb begin
    obs_ready = (sel == 0) ? rdy0 : rdy1;
    obs_valid = (sel == 0) ? dv0  : dv1;
    obs_ovf   = (sel == 0) ? ovf0 : ovf1;
    obs_h     = (sel == 0) ? h0   : 768'(h1);
    obs_y     = (sel == 0) ? y0   : 192'(y1);
  end

  // Reference model: a frame is just the list of accepted words; up to two frames wait.
  int          nr, nc, dw, F;
  logic [47:0] mask;
  frame_t      pend[$];
  frame_t      cur, junk;
  int          cur_cnt;
  bit          m_ovf;
  int          n_checks = 0, n_fail = 0;

  function automatic logic [767:0] exp_h(frame_t fr);
    logic [767:0] v = '0;
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nc; c++)
        v |= 768'(fr[(r*(nc+1)+c)*48 +: 48]) << ((r*nc+c)*dw);
    return v;
  endfunction

  function automatic logic [191:0] exp_y(frame_t fr);
    logic [191:0] v = '0;
    for (int r = 0; r < nr; r++)
      v |= 192'(fr[(r*(nc+1)+nc)*48 +: 48]) << (r*dw);
    return v;
  endfunction

  function automatic logic [47:0] h_el(int r, int c);
    return 48'(obs_h >> ((r*nc+c)*dw)) & mask;
  endfunction

  function automatic logic [47:0] y_el(int r);
    return 48'(obs_y >> (r*dw)) & mask;
  endfunction

  function automatic logic [47:0] rnd_word();
    return {$urandom, $urandom} & 64'(mask);
  endfunction

  function automatic logic [47:0] idx_word(int k);
    return ((48'(k) << (dw/2)) | 48'(k)) & mask;
  endfunction

  task automatic model_reset();
    pend.delete();
    cur_cnt = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input bit v, input logic [47:0] d, input bit f, input bit r);
    bit mr, mv;
    vld = v; data = d & mask; flush = f; rdy = r;
    @(posedge clk);
    mr = (pend.size() < 2);
    mv = (pend.size() > 0);
    if (mv && r) junk = pend.pop_front();
    if (f) cur_cnt = 0;
    else if (v && mr) begin
      cur[cur_cnt*48 +: 48] = d & mask;
      cur_cnt++;
      if (cur_cnt == F) begin
        pend.push_back(cur);
        cur_cnt = 0;
      end
    end else if (v) m_ovf = 1'b1;
    @(negedge clk);
    vld = 1'b0; flush = 1'b0; rdy = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", obs_valid); end
    n_checks++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", obs_ready); end
    n_checks++; if (obs_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", obs_ovf); end
    n_checks++; if (obs_h !== '0) begin n_fail++; $display("FAIL reset_h: got %h want 0", obs_h); end
    n_checks++; if (obs_y !== '0) begin n_fail++; $display("FAIL reset_y: got %h want 0", obs_y); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    logic [767:0] snap_h;
    logic [191:0] snap_y;
    apply_reset();
    for (int i = 0; i < F; i++) begin
      step(1'b1, idx_word(i + 1), 1'b0, 1'b0);
      n_checks++;
      if (obs_valid !== (i == F - 1)) begin n_fail++; $display("FAIL single_valid word %0d: got %b want %b", i + 1, obs_valid, i == F - 1); end
    end
    n_checks++; if (h_el(0, 0) !== idx_word(1)) begin n_fail++; $display("FAIL single_h00: got %h want %h", h_el(0, 0), idx_word(1)); end
    n_checks++; if (h_el(0, nc-1) !== idx_word(nc)) begin n_fail++; $display("FAIL single_h0last: got %h want %h", h_el(0, nc-1), idx_word(nc)); end
    n_checks++; if (y_el(0) !== idx_word(nc+1)) begin n_fail++; $display("FAIL single_y0: got %h want %h", y_el(0), idx_word(nc+1)); end
    n_checks++; if (h_el(1, 0) !== idx_word(nc+2)) begin n_fail++; $display("FAIL single_h10: got %h want %h", h_el(1, 0), idx_word(nc+2)); end
    n_checks++; if (y_el(nr-1) !== idx_word(F)) begin n_fail++; $display("FAIL single_ylast: got %h want %h", y_el(nr-1), idx_word(F)); end
    snap_h = obs_h; snap_y = obs_y;
    repeat (3) step(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (obs_valid !== 1'b1 || obs_h !== snap_h || obs_y !== snap_y) begin n_fail++; $display("FAIL single_hold: valid %b, outputs changed %b", obs_valid, obs_h !== snap_h || obs_y !== snap_y); end
    step(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin n_fail++; $display("FAIL single_consume: valid %b ready %b want 0 1", obs_valid, obs_ready); end
  endtask

  task automatic test_random_gaps();
    int frames = 0, cyc = 0;
    bit pulse = 1'b0;
    apply_reset();
    while (frames < 3 && cyc < 2000) begin
      step($urandom_range(9) >= 3, rnd_word(), 1'b0, pulse);
      pulse = 1'b0;
      cyc++;
      n_checks++;
      if (obs_valid !== (pend.size() > 0) || obs_ready !== (pend.size() < 2)) begin
        n_fail++; $display("FAIL gaps_handshake cyc %0d: valid %b ready %b want %b %b", cyc, obs_valid, obs_ready, pend.size() > 0, pend.size() < 2);
      end
      if (pend.size() > 0) begin
        n_checks++; if (obs_h !== exp_h(pend[0])) begin n_fail++; $display("FAIL gaps_h frame %0d: got %h want %h", frames, obs_h, exp_h(pend[0])); end
        n_checks++; if (obs_y !== exp_y(pend[0])) begin n_fail++; $display("FAIL gaps_y frame %0d: got %h want %h", frames, obs_y, exp_y(pend[0])); end
        pulse = 1'b1;
        frames++;
      end
    end
    step(1'b0, '0, 1'b0, pulse);
    n_checks++; if (frames != 3) begin n_fail++; $display("FAIL gaps_budget: got %0d frames want 3", frames); end
    n_checks++; if (obs_ovf !== 1'b0) begin n_fail++; $display("FAIL gaps_ovf: got %b want 0", obs_ovf); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 2*F; i++) step(1'b1, rnd_word(), 1'b0, 1'b0);
    n_checks++; if (obs_ready !== 1'b0 || obs_valid !== 1'b1) begin n_fail++; $display("FAIL bp_full: ready %b valid %b want 0 1", obs_ready, obs_valid); end
    n_checks++; if (obs_h !== exp_h(pend[0])) begin n_fail++; $display("FAIL bp_frame1_h: got %h want %h", obs_h, exp_h(pend[0])); end
    step(1'b1, rnd_word(), 1'b0, 1'b0);
    n_checks++; if (obs_ovf !== 1'b1 || m_ovf !== 1'b1) begin n_fail++; $display("FAIL bp_ovf: got %b want 1", obs_ovf); end
    step(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (obs_valid !== 1'b1 || obs_ready !== 1'b1) begin n_fail++; $display("FAIL bp_after_consume: valid %b ready %b want 1 1", obs_valid, obs_ready); end
    n_checks++; if (obs_h !== exp_h(pend[0])) begin n_fail++; $display("FAIL bp_frame2_h: got %h want %h", obs_h, exp_h(pend[0])); end
    n_checks++; if (obs_y !== exp_y(pend[0])) begin n_fail++; $display("FAIL bp_frame2_y: got %h want %h", obs_y, exp_y(pend[0])); end
    // A third frame must start at slot 0: the dropped word may not have moved the counters.
    for (int i = 0; i < F; i++) step(1'b1, rnd_word(), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (obs_valid !== 1'b1 || obs_h !== exp_h(pend[0])) begin n_fail++; $display("FAIL bp_frame3_h: valid %b got %h want %h", obs_valid, obs_h, exp_h(pend[0])); end
    n_checks++; if (obs_y !== exp_y(pend[0])) begin n_fail++; $display("FAIL bp_frame3_y: got %h want %h", obs_y, exp_y(pend[0])); end
    n_checks++; if (obs_ovf !== 1'b1) begin n_fail++; $display("FAIL bp_ovf_sticky: got %b want 1", obs_ovf); end
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_simultaneous();
    apply_reset();
    for (int i = 0; i < 2*F - 1; i++) step(1'b1, rnd_word(), 1'b0, 1'b0);
    step(1'b1, rnd_word(), 1'b0, 1'b1);
    n_checks++; if (obs_valid !== 1'b1 || obs_ready !== 1'b1) begin n_fail++; $display("FAIL simul_handshake: valid %b ready %b want 1 1", obs_valid, obs_ready); end
    n_checks++; if (obs_h !== exp_h(pend[0])) begin n_fail++; $display("FAIL simul_h: got %h want %h", obs_h, exp_h(pend[0])); end
    n_checks++; if (obs_y !== exp_y(pend[0])) begin n_fail++; $display("FAIL simul_y: got %h want %h", obs_y, exp_y(pend[0])); end
    step(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL simul_drain: valid %b want 0", obs_valid); end
  endtask

  task automatic test_flush();
    logic [47:0] first;
    apply_reset();
    for (int i = 0; i < 7; i++) step(1'b1, rnd_word(), 1'b0, 1'b0);
    step(1'b1, rnd_word(), 1'b1, 1'b0);
    first = rnd_word();
    step(1'b1, first, 1'b0, 1'b0);
    for (int i = 1; i < F; i++) step(1'b1, rnd_word(), 1'b0, 1'b0);
    n_checks++; if (obs_valid !== 1'b1) begin n_fail++; $display("FAIL flush_valid: got %b want 1", obs_valid); end
    n_checks++; if (h_el(0, 0) !== first) begin n_fail++; $display("FAIL flush_h00: got %h want %h", h_el(0, 0), first); end
    n_checks++; if (obs_h !== exp_h(pend[0]) || obs_y !== exp_y(pend[0])) begin n_fail++; $display("FAIL flush_frame: h %h want %h", obs_h, exp_h(pend[0])); end
    n_checks++; if (obs_ovf !== 1'b0) begin n_fail++; $display("FAIL flush_ovf: got %b want 0", obs_ovf); end
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < F + (F*3)/5; i++) step(1'b1, rnd_word(), 1'b0, 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++; if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_hs: valid %b ready %b want 0 1", obs_valid, obs_ready); end
    n_checks++; if (obs_h !== '0 || obs_y !== '0) begin n_fail++; $display("FAIL rstmid_data: h %h want 0", obs_h); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < F; i++) step(1'b1, rnd_word(), 1'b0, 1'b0);
    n_checks++; if (obs_valid !== 1'b1 || obs_h !== exp_h(pend[0])) begin n_fail++; $display("FAIL rstmid_frame_h: valid %b got %h want %h", obs_valid, obs_h, exp_h(pend[0])); end
    n_checks++; if (obs_y !== exp_y(pend[0])) begin n_fail++; $display("FAIL rstmid_frame_y: got %h want %h", obs_y, exp_y(pend[0])); end
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      sel = p;
      if (p == 0) begin nr = 4; nc = 4; dw = 48; end
      else        begin nr = 2; nc = 3; dw = 16; end
      F    = nr * (nc + 1);
      mask = 48'((64'd1 << dw) - 1);
      test_reset();
      test_single_frame();
      test_random_gaps();
      test_back_to_back();
      test_simultaneous();
      test_flush();
      test_reset_mid();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mimo_frame_collector.md
Name: mimo_frame_collector

Overview:
- Parametrised, double-buffered deserialiser for the channel-matrix front end.
- Collects a serial stream of complex words into an N_ROW x N_COL matrix H plus an N_ROW vector Y, then presents the completed frame to the QR/CORDIC core through a valid/ready handshake.
- Uses two frame banks (ping-pong), so the next frame is captured while the core still holds the previous one.
- Adds backpressure, frame flush and overflow reporting.

Parameters:
- N_ROW, 4, number of rows of H and number of elements of Y.
- N_COL, 4, number of columns of H.
- DATA_W, 48, width of one complex element, packed as {imag[DATA_W/2-1:0], real[DATA_W/2-1:0]}. Must be even.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_input_valid  in  1  i_data carries a word this cycle.
- i_data  in  DATA_W  input word.
- i_flush  in  1  synchronous; discards the partially collected frame.
- o_in_ready  out  1  a free bank exists, so a word offered this cycle is accepted.
- o_data_valid  out  1  a complete frame is presented on o_h/o_y.
- i_data_ready  in  1  the consumer takes the presented frame this cycle.
- o_h  out  N_ROW*N_COL*DATA_W  H element (r,c), 0-based, at [(r*N_COL+c)*DATA_W +: DATA_W].
- o_y  out  N_ROW*DATA_W  Y element r at [r*DATA_W +: DATA_W].
- o_overflow  out  1  sticky; a word arrived while o_in_ready was low.

Behaviour:
- Stream order per frame: for r = 0..N_ROW-1, send H(r,0)..H(r,N_COL-1), then Y(r).
  - Frame length F = N_ROW*(N_COL+1) words; 20 at the defaults.
- State:
  - col counter 0..N_COL (value N_COL means the Y slot).
  - row counter 0..N_ROW-1.
  - wr_sel, rd_sel (1 bit each).
  - full[1:0] (one flag per bank).
- Reset (asynchronous): all bank storage = 0, counters = 0, wr_sel = rd_sel = 0, full = 00, o_overflow = 0.
  - Hence o_data_valid = 0, o_in_ready = 1, and o_h/o_y = 0.
  - No dead start cycle: the word on the first edge after reset release is accepted.
- o_in_ready = !full[wr_sel] (combinational from registers).
- Accept = i_input_valid & o_in_ready & !i_flush.
  - On accept, the word is written into bank wr_sel at the (row, col) slot.
  - The column counter advances; on wrap (after the Y slot) col = 0 and row increments.
  - Gaps in i_input_valid stall the counters and lose nothing.
- Frame completion: accepting the last word (row = N_ROW-1, col = N_COL) on edge k sets full[wr_sel], toggles wr_sel and clears both counters.
  - o_data_valid rises in the cycle after edge k.
- o_data_valid = full[rd_sel].
  - o_h/o_y = contents of bank rd_sel, muxed combinationally on rd_sel.
  - Outputs hold stable while o_data_valid = 1 and the frame is not consumed.
- Consume: o_data_valid & i_data_ready at an edge clears full[rd_sel] and toggles rd_sel.
  - If the other bank is full, o_data_valid stays high in the next cycle showing that frame; otherwise it drops.
- Completion and consume on the same edge act on different banks and both take effect.
  - Example: bank 0 consumed while bank 1 completes gives full = 10, rd_sel = 1, valid stays 1.
- Backpressure: with both banks full, o_in_ready = 0.
  - i_input_valid = 1 in that state drops the word and sets o_overflow (held until reset).
  - Counters do not move.
  - o_in_ready returns to 1 in the cycle after a consume.
- i_flush = 1 at an edge clears both counters; a same-cycle word is discarded, and o_overflow is not set by it.
  - full, wr_sel, rd_sel and completed banks are unaffected.
  - Stale slot data in bank wr_sel is overwritten by the next frame.
- Reset asserted mid-frame or mid-handshake: immediate return to the reset state; the partial frame and any pending frames are lost.
- Bank storage: 2*F*DATA_W flops. Only the addressed slot is written per accept, with no other datapath arithmetic.

Test Plan:
- Single frame, defaults:
  - Stimulus: 20 back-to-back words, value = word index+1 in both halves; i_data_ready = 0.
  - Response: o_data_valid rises the cycle after word 20. H(0,0)=1, H(0,3)=4, Y(0)=5, H(1,0)=6, Y(3)=20. Outputs stable until ready.
- Random valid gaps (30% idle) over 3 frames with i_data_ready pulsed after each frame:
  - Response: every slot matches the scoreboard; o_overflow = 0.
- Ping-pong and backpressure:
  - Stimulus: 2 frames with ready = 0, then 1 more word.
  - Response: o_in_ready = 0 after word 40; word 41 dropped; o_overflow = 1.
  - Then a one-cycle ready pulse: frame 1 leaves, frame 2 presented next cycle, o_in_ready = 1.
- Simultaneous consume and completion:
  - Stimulus: ready = 1 on the exact edge that accepts the last word of frame 2.
  - Response: valid stays 1 and shows frame 2; full = 10.
- Flush:
  - Stimulus: 7 words, then i_flush together with a valid word, then a full frame.
  - Response: the delivered frame contains only the new 20 words, H(0,0) = first post-flush word; o_overflow = 0.
- Reset and parameters:
  - Stimulus: reset mid-frame at word 12.
  - Response: valid = 0, in_ready = 1, o_h = 0 while reset is high; the next 20 words form a correct frame.
  - Repeat all scenarios at N_ROW=2, N_COL=3, DATA_W=16 (F = 8).
